// File: rtl/id_pkg.sv
// -----------------------------------------------------------------------------
// id_pkg
// Shared definitions for the instruction front end (fetch unit and decoder).
//
// Contents:
//   INSTR_WIDTH / OPCODE_WIDTH / PC_WIDTH : default datapath widths
//   opcode_t       : instruction opcodes understood by the decoder
//   NOP_WORD       : a full instruction word holding the NOP opcode,
//                    zero-extended; presented whenever no word is valid
//   fetch_state_t  : states of the instruction fetch unit FSM
//   PC_RESET_VALUE : program counter value after reset
// -----------------------------------------------------------------------------
package id_pkg;

  localparam int INSTR_WIDTH  = 16;
  localparam int OPCODE_WIDTH = 4;
  localparam int PC_WIDTH     = 5;

  // Opcode field sits in the low bits of the instruction word.
  typedef enum logic [OPCODE_WIDTH-1:0] {
    OP_NOP   = 4'h0,
    OP_LOAD  = 4'h1,
    OP_STORE = 4'h2,
    OP_ADD   = 4'h3,
    OP_SUB   = 4'h4,
    OP_JMP   = 4'h5,
    OP_JZ    = 4'h6
  } opcode_t;

  localparam logic [INSTR_WIDTH-1:0] NOP_WORD =
    {{(INSTR_WIDTH - OPCODE_WIDTH){1'b0}}, OP_NOP};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    ISSUE = 3'd3,
    HALT  = 3'd4
  } fetch_state_t;

  localparam logic [PC_WIDTH-1:0] PC_RESET_VALUE = '0;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit_if
// Bundles the fetch unit's bus-side signals:
//   imem_req / imem_addr             : fetch unit -> instruction memory
//   imem_rdata / imem_valid          : instruction memory -> fetch unit
//   instruction / instr_valid        : fetch unit -> decoder
//   instr_ready                      : decoder -> fetch unit
//   PC_jump_enable / PC_jump_value   : decoder -> fetch unit (redirect)
//
// Modports:
//   master : the fetch unit's view
//   slave  : the environment's view (memory + decoder)
// -----------------------------------------------------------------------------
interface instruction_fetch_unit_if #(
  parameter int INSTRUCTION_WIDTH = 16,
  parameter int PC_VALUE_WIDTH    = 5
);

  logic                         imem_req;
  logic [PC_VALUE_WIDTH-1:0]    imem_addr;
  logic [INSTRUCTION_WIDTH-1:0] imem_rdata;
  logic                         imem_valid;

  logic [INSTRUCTION_WIDTH-1:0] instruction;
  logic                         instr_valid;
  logic                         instr_ready;

  logic                         PC_jump_enable;
  logic [PC_VALUE_WIDTH-1:0]    PC_jump_value;

  modport master (
    output imem_req, imem_addr, instruction, instr_valid,
    input  imem_rdata, imem_valid, instr_ready, PC_jump_enable, PC_jump_value
  );

  modport slave (
    input  imem_req, imem_addr, instruction, instr_valid,
    output imem_rdata, imem_valid, instr_ready, PC_jump_enable, PC_jump_value
  );

endinterface

// File: rtl/program_counter.sv
// -----------------------------------------------------------------------------
// program_counter
// Architectural PC register with load / increment / hold control.
//
// Ports:
//   clk, rst       : clock and synchronous active-high reset
//   load_i         : load load_value_i (has priority over incr_i)
//   load_value_i   : jump target
//   incr_i         : advance by one, wrapping modulo 2^WIDTH
//   pc_o           : current PC
//   at_max_o       : PC is at its top value; the next increment wraps
// -----------------------------------------------------------------------------
module program_counter
  import id_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic             incr_i,
  output logic [WIDTH-1:0] pc_o,
  output logic             at_max_o
);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;

  // Next-PC selection: a jump wins over sequential advance; otherwise hold.
  // The increment naturally wraps because the sum is truncated to WIDTH.
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_value_i;
    end else if (incr_i) begin
      pc_d = pc_q + WIDTH'(1);
    end
  end

  // PC register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= WIDTH'(PC_RESET_VALUE);
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o     = pc_q;
  assign at_max_o = &pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
// Fetches one instruction word at a time from instruction memory at the
// current PC and presents it to the decoder. When the decoder accepts the
// word, the PC advances by one or takes the decoder's jump target.
//
// Ports:
//   clk, rst  : clock and synchronous active-high reset
//   run       : level-sensitive fetch enable
//   bus       : instruction_fetch_unit_if.master (memory + decoder handshakes)
//   pc        : architectural PC
//   halted    : unit sits in HALT (only possible with IFU_WRAP_HALT_EN)
//
// Build option:
//   IFU_WRAP_HALT_EN : an accepted word at the top PC without a jump sends the
//                      unit to a terminal HALT state instead of wrapping to 0.
// -----------------------------------------------------------------------------
module instruction_fetch_unit
  import id_pkg::*;
#(
  parameter int INSTRUCTION_WIDTH = INSTR_WIDTH,
  parameter int PC_VALUE_WIDTH    = PC_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      run,
  instruction_fetch_unit_if.master  bus,
  output logic [PC_VALUE_WIDTH-1:0] pc,
  output logic                      halted
);

`ifdef IFU_WRAP_HALT_EN
  localparam bit WrapHalts = 1'b1;
`else
  localparam bit WrapHalts = 1'b0;
`endif

  fetch_state_t                 state_q;
  fetch_state_t                 state_d;
  logic [INSTRUCTION_WIDTH-1:0] instr_q;
  logic [INSTRUCTION_WIDTH-1:0] instr_d;

  logic pc_load;
  logic pc_incr;
  logic pc_at_max;
  logic imem_req;
  logic instr_valid;
  logic accept;

  program_counter #(
    .WIDTH (PC_VALUE_WIDTH)
  ) u_program_counter (
    .clk          (clk),
    .rst          (rst),
    .load_i       (pc_load),
    .load_value_i (bus.PC_jump_value),
    .incr_i       (pc_incr),
    .pc_o         (pc),
    .at_max_o     (pc_at_max)
  );

  // State and instruction registers. Resetting to IDLE also drops any memory
  // response still in flight, since IDLE never looks at imem_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      instr_q <= NOP_WORD;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
    end
  end

  assign accept = (state_q == ISSUE) && bus.instr_ready;

  // Next-state and control decode. The instruction register only changes on
  // a memory response (load) or on acceptance (back to NOP), so the word
  // stays stable while the decoder stalls. The jump request is only looked
  // at on the accept cycle because the decoder derives it combinationally
  // from the word we are presenting.
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    pc_load     = 1'b0;
    pc_incr     = 1'b0;
    imem_req    = 1'b0;
    instr_valid = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (run) begin
          state_d = REQ;
        end
      end

      REQ, WAIT: begin
        imem_req = 1'b1;
        if (bus.imem_valid) begin
          instr_d = bus.imem_rdata;
          state_d = ISSUE;
        end else begin
          state_d = WAIT;
        end
      end

      ISSUE: begin
        instr_valid = 1'b1;
        if (accept) begin
          instr_d = NOP_WORD;
          state_d = run ? REQ : IDLE;
          if (bus.PC_jump_enable) begin
            pc_load = 1'b1;
          end else if (pc_at_max && WrapHalts) begin
            state_d = HALT;
          end else begin
            pc_incr = 1'b1;
          end
        end
      end

      HALT: begin
        state_d = WrapHalts ? HALT : IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.imem_req    = imem_req;
  assign bus.imem_addr   = imem_req ? pc : '0;
  assign bus.instr_valid = instr_valid;
  assign bus.instruction = instr_q;

`ifdef IFU_WRAP_HALT_EN
  assign halted = (state_q == HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Upstream neighbour of instruction_decoder.
- Owns the 5-bit program counter and fetches 16-bit instruction words from instruction memory over a req/valid handshake.
- Presents one instruction at a time to the decoder/execute stage over a valid/ready handshake.
- Consumes the decoder's PC_jump_enable/PC_jump_value to redirect the PC.

Parameters:
- INSTRUCTION_WIDTH, 16, instruction word width.
- PC_VALUE_WIDTH, 5, PC and instruction-memory address width (32 words).

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- run  input  1  fetch enable; level-sensitive.
- imem_req  output  1  instruction-memory read request.
- imem_addr  output  PC_VALUE_WIDTH  read address (current PC).
- imem_rdata  input  INSTRUCTION_WIDTH  read data, valid only with imem_valid.
- imem_valid  input  1  read data strobe.
- instruction  output  INSTRUCTION_WIDTH  word to the decoder.
- instr_valid  output  1  instruction holds a fetched word.
- instr_ready  input  1  downstream accepts the word this cycle.
- PC_jump_enable  input  1  from the decoder; jump request.
- PC_jump_value  input  PC_VALUE_WIDTH  jump target.
- pc  output  PC_VALUE_WIDTH  architectural PC.
- halted  output  1  unit is in HALT.

Behaviour:
- Reset (rst=1 at a clock edge):
  - pc=0, imem_req=0, imem_addr=0, instr_valid=0, halted=0, state=IDLE.
  - instruction = NOP_WORD (zero-extended NOP opcode from id_pkg).
  - A memory response still in flight is discarded.
- FSM states: IDLE, REQ, WAIT, ISSUE, HALT.
- IDLE:
  - Outputs idle.
  - run=1 → REQ next cycle.
- REQ:
  - imem_req=1, imem_addr=pc.
  - imem_valid=1 in the same cycle → latch imem_rdata, go to ISSUE.
  - Otherwise → WAIT.
- WAIT:
  - imem_req stays 1 and imem_addr stays stable until imem_valid=1.
  - Then latch imem_rdata → ISSUE.
- ISSUE:
  - instr_valid=1; instruction = latched word, held stable while instr_ready=0.
  - On acceptance (instr_valid & instr_ready):
    - PC_jump_enable=1 → pc ← PC_jump_value.
    - Otherwise pc ← pc+1, modulo 2^PC_VALUE_WIDTH.
    - Next state: REQ if run=1, else IDLE.
  - Next-cycle outputs: instr_valid=0, instruction=NOP_WORD.
- Jump sampling:
  - PC_jump_enable is sampled only on the accept cycle in ISSUE and ignored at all other times.
  - The decoder is combinational, so the jump comes from the word currently presented.
  - A jump target equal to pc is legal (tight loop).
- imem_valid outside REQ/WAIT is ignored.
- run deasserted mid-fetch: the current fetch and issue complete, then the unit goes to IDLE. The PC is kept and resumes on the next run=1.
- Wrap-around: pc=31 with no jump → pc=0.
- Latency:
  - Minimum run-to-instr_valid: 2 cycles (IDLE→REQ→ISSUE with zero-wait memory).
  - Throughput: one instruction per 2 cycles at best.
- HALT: reached only under IFU_WRAP_HALT_EN. Terminal until rst; halted=1, imem_req=0, instr_valid=0.

Optional Feature:
- Macro: IFU_WRAP_HALT_EN.
- Defined: an accept at pc=31 with no jump → HALT instead of wrapping. pc holds 31 and halted=1. An accept at pc=31 with a jump behaves normally.
- Undefined: pc wraps to 0. The HALT state is unreachable and halted is tied 0.

Decomposition:
- Add to id_pkg:
  - fetch_state_t enum {IDLE, REQ, WAIT, ISSUE, HALT}.
  - NOP_WORD constant, built from the existing NOP instruction code.
  - PC_RESET_VALUE constant (0).
- Natural sub-module: program_counter. Holds the pc register with load/increment/hold controls, reset value, and wrap/halt-condition output.
- The FSM and instruction register stay in instruction_fetch_unit.

Test Plan:
- Zero-wait memory, run=1, instr_ready=1, no jumps:
  - imem_addr sequence 0,1,2,3.
  - instr_valid pulses every 2nd cycle.
  - instruction equals imem_rdata of each address.
- Memory valid delayed 3 cycles at pc=4:
  - imem_req high for 4 cycles with imem_addr=4 stable.
  - Word latched on the valid cycle.
  - Hold instr_ready=0 for 5 cycles → instruction stable, pc stays 4.
- Jump on accept at pc=6 with PC_jump_value=17:
  - Next imem_addr=17.
  - PC_jump_enable pulsed while instr_valid=0 → ignored, pc unchanged.
- Wrap at pc=31 without the macro → next imem_addr=0. With IFU_WRAP_HALT_EN → halted=1, imem_req stays 0, pc=31.
- rst asserted during WAIT (pc=9) with a late imem_valid the next cycle:
  - All outputs at reset values; pc=0.
  - The late response is ignored; the fetch restarts at address 0 after run.
- run dropped during WAIT at pc=12:
  - Word issued and accepted, pc=13, FSM → IDLE, imem_req=0.
  - run reasserted → fetch resumes at 13.
